// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the feed-forward network: walks each layer through weight fetch, MAC,
// activation and vector store, and arbitrates the weight RAM port with the weight loader.
module nn_layer_sequencer #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ACT_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [255:0]      ld_data,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [255:0]      mem_wdata,
  output logic              wt_load,
  output logic              mac_en,
  output logic              act_en,
  output logic              vec_we,
  output logic              in_sel,
  output logic [3:0]        layer_idx
);

  localparam int unsigned CNT_W = $clog2(ACT_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, LOAD, MAC, ACT, STORE, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        layer_q, layer_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              pending_q, pending_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              ld_win;

  logic busy_q, done_q, wt_load_q, mac_en_q, act_en_q, vec_we_q, in_sel_q;

  // The loader owns the RAM port only while the sequencer is idle
  assign ld_win = (state == IDLE) && ld_req;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      layer_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= state_nxt;
      layer_q   <= layer_nxt;
      cnt_q     <= cnt_nxt;
      pending_q <= pending_nxt;
      addr_q    <= addr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    layer_nxt   = layer_q;
    cnt_nxt     = cnt_q;
    pending_nxt = pending_q;
    addr_nxt    = addr_q;
    case (state)
      IDLE: begin
        if (ld_req) begin
          if (start) pending_nxt = 1'b1;
        end else if (start || pending_q) begin
          state_nxt   = FETCH;
          layer_nxt   = 4'd0;
          pending_nxt = 1'b0;
          addr_nxt    = ADDR_W'(BASE_ADDR);
        end
      end
      FETCH: state_nxt = WAIT;
      WAIT:  state_nxt = LOAD;
      LOAD:  state_nxt = MAC;
      MAC: begin
        state_nxt = ACT;
        cnt_nxt   = '0;
      end
      ACT: begin
        if (cnt_q == CNT_W'(ACT_LAT - 1)) state_nxt = STORE;
        else                              cnt_nxt   = cnt_q + CNT_W'(1);
      end
      STORE: begin
        if (layer_q == 4'(NUM_LAYERS - 1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FETCH;
          layer_nxt = layer_q + 4'd1;
          addr_nxt  = ADDR_W'(BASE_ADDR) + ADDR_W'(layer_q + 4'd1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each is a flop output aligned with its state
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wt_load_q <= 1'b0;
      mac_en_q  <= 1'b0;
      act_en_q  <= 1'b0;
      vec_we_q  <= 1'b0;
      in_sel_q  <= 1'b0;
    end else begin
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);
      wt_load_q <= (state_nxt == LOAD);
      mac_en_q  <= (state_nxt == MAC);
      act_en_q  <= (state_nxt == ACT) && (state != ACT);
      vec_we_q  <= (state_nxt == STORE);
      in_sel_q  <= (state_nxt != IDLE) && (layer_nxt != 4'd0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wt_load   = wt_load_q;
  assign mac_en    = mac_en_q;
  assign act_en    = act_en_q;
  assign vec_we    = vec_we_q;
  assign in_sel    = in_sel_q;
  assign layer_idx = layer_q;

  // Loader grant and its RAM write are combinational in the granted IDLE cycle
  assign ld_gnt    = ld_win;
  assign mem_we    = ld_win;
  assign mem_addr  = ld_win ? ld_addr : addr_q;
  assign mem_wdata = ld_win ? ld_data : '0;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: default instance with a RAM model, plus a
// 3-layer / ACT_LAT=3 instance for the multi-cycle activation timing.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: NUM_LAYERS=2, ACT_LAT=1
  logic         start_a, busy_a, done_a, ld_req_a, ld_gnt_a, mem_we_a;
  logic [3:0]   ld_addr_a, mem_addr_a, layer_a;
  logic [255:0] ld_data_a, mem_wdata_a;
  logic         wt_load_a, mac_en_a, act_en_a, vec_we_a, in_sel_a;

  // Instance B: NUM_LAYERS=3, ACT_LAT=3
  logic         start_b, busy_b, done_b, ld_gnt_b, mem_we_b;
  logic [3:0]   mem_addr_b, layer_b;
  logic [255:0] mem_wdata_b;
  logic         wt_load_b, mac_en_b, act_en_b, vec_we_b, in_sel_b;
  logic         ld_req_b = 1'b0;
  logic [3:0]   ld_addr_b = 4'd0;
  logic [255:0] ld_data_b = '0;

  nn_layer_sequencer u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .ld_req(ld_req_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a), .ld_gnt(ld_gnt_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
    .wt_load(wt_load_a), .mac_en(mac_en_a), .act_en(act_en_a), .vec_we(vec_we_a),
    .in_sel(in_sel_a), .layer_idx(layer_a)
  );

  nn_layer_sequencer #(.NUM_LAYERS(3), .ACT_LAT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .ld_req(ld_req_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b), .ld_gnt(ld_gnt_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .wt_load(wt_load_b), .mac_en(mac_en_b), .act_en(act_en_b), .vec_we(vec_we_b),
    .in_sel(in_sel_b), .layer_idx(layer_b)
  );

  // Weight RAM model with one-cycle read latency
  logic [255:0] ram [16];
  logic [255:0] rdata_a;
  always @(posedge clk) begin
    if (mem_we_a) ram[mem_addr_a] <= mem_wdata_a;
    rdata_a <= ram[mem_addr_a];
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample instance A for max cycles; index 0 is the cycle right after the start edge
  task automatic mon_a(input int max, output int done_at, output int n_done, output int n_vec,
                       output int gnt_busy, output int first_gnt, output int we_busy,
                       output logic [3:0] a0, output logic [3:0] a1,
                       output logic s0, output logic s1, output logic [255:0] l1_data);
    done_at = -1; n_done = 0; n_vec = 0; gnt_busy = 0; first_gnt = -1; we_busy = 0;
    a0 = 4'hF; a1 = 4'hF; s0 = 1'bx; s1 = 1'bx; l1_data = '0;
    for (int i = 0; i < max; i++) begin
      if (done_a) begin
        if (done_at < 0) done_at = i;
        n_done++;
      end
      if (vec_we_a) n_vec++;
      if (ld_gnt_a && busy_a) gnt_busy++;
      if (mem_we_a && busy_a) we_busy++;
      if (ld_gnt_a && first_gnt < 0) first_gnt = i;
      if (wt_load_a && layer_a == 4'd0) begin a0 = mem_addr_a; s0 = in_sel_a; end
      if (wt_load_a && layer_a == 4'd1) begin a1 = mem_addr_a; s1 = in_sel_a; l1_data = rdata_a; end
      tick();
    end
  endtask

  int done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy;
  logic [3:0] a0, a1;
  logic s0, s1;
  logic [255:0] l1_data;
  logic [255:0] pat_a5, pat_2, pat_3;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_2  = {16{16'h1234}};
    pat_3  = {8{32'hDEAD_BEEF}};
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ld_req_a = 1'b0; ld_addr_a = 4'd0; ld_data_a = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 256'(busy_a), 256'(0));
    chk("rst_done", 256'(done_a), 256'(0));
    chk("rst_gnt", 256'(ld_gnt_a), 256'(0));
    chk("rst_we", 256'(mem_we_a), 256'(0));
    chk("rst_strobes", 256'({wt_load_a, mac_en_a, act_en_a, vec_we_a, in_sel_a}), 256'(0));
    chk("rst_layer", 256'(layer_a), 256'(0));
    chk("rst_addr", 256'(mem_addr_a), 256'(0));
    reset = 1'b0;
    tick();

    // 1: plain inference
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("c1_busy", 256'(busy_a), 256'(1));
    chk("c1_fetch_addr", 256'(mem_addr_a), 256'(0));
    mon_a(20, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    chk_i("c1_done_at", done_at, 12);
    chk_i("c1_done_cnt", n_done, 1);
    chk_i("c1_vec_cnt", n_vec, 2);
    chk_i("c1_we_busy", we_busy, 0);
    chk("c1_addr0", 256'(a0), 256'(0));
    chk("c1_addr1", 256'(a1), 256'(1));
    chk("c1_insel0", 256'(s0), 256'(0));
    chk("c1_insel1", 256'(s1), 256'(1));
    chk("c1_idle", 256'(busy_a), 256'(0));

    // 2: loader write in IDLE, then read back through layer 1
    ld_req_a = 1'b1; ld_addr_a = 4'd1; ld_data_a = pat_a5; #1;
    chk("c2_gnt", 256'(ld_gnt_a), 256'(1));
    chk("c2_we", 256'(mem_we_a), 256'(1));
    chk("c2_addr", 256'(mem_addr_a), 256'(1));
    chk("c2_wdata", mem_wdata_a, pat_a5);
    tick(); ld_req_a = 1'b0; #1;
    chk("c2_gnt_off", 256'(ld_gnt_a), 256'(0));
    start_a = 1'b1; tick(); start_a = 1'b0;
    mon_a(20, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    chk("c2_l1_data", l1_data, pat_a5);
    chk_i("c2_done_at", done_at, 12);

    // 3: start and ld_req collide; loader wins, inference deferred one cycle
    start_a = 1'b1; ld_req_a = 1'b1; ld_addr_a = 4'd2; ld_data_a = pat_2; #1;
    chk("c3_gnt", 256'(ld_gnt_a), 256'(1));
    tick(); start_a = 1'b0; ld_req_a = 1'b0;
    chk("c3_still_idle", 256'(busy_a), 256'(0));
    chk("c3_ram", ram[2], pat_2);
    mon_a(20, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    chk_i("c3_done_at", done_at, 13);
    chk_i("c3_done_cnt", n_done, 1);

    // 4: loader request during busy waits until the cycle after done
    start_a = 1'b1; tick(); start_a = 1'b0;
    ld_req_a = 1'b1; ld_addr_a = 4'd3; ld_data_a = pat_3;
    mon_a(16, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    ld_req_a = 1'b0;
    chk_i("c4_gnt_busy", gnt_busy, 0);
    chk_i("c4_first_gnt", first_gnt, 13);
    chk_i("c4_done_at", done_at, 12);
    chk("c4_ram", ram[3], pat_3);

    // 4b: start while busy is ignored and not queued
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); start_a = 1'b1; tick(); start_a = 1'b0;
    mon_a(20, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    chk_i("c4b_done_cnt", n_done, 1);

    // 5: reset in ACT of layer 1 aborts
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (10) tick();
    chk("c5_in_act", 256'({act_en_a, layer_a}), 256'({1'b1, 4'd1}));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("c5_busy", 256'(busy_a), 256'(0));
    chk("c5_strobes", 256'({done_a, wt_load_a, mac_en_a, act_en_a, vec_we_a, in_sel_a}), 256'(0));
    chk("c5_layer", 256'(layer_a), 256'(0));
    mon_a(10, done_at, n_done, n_vec, gnt_busy, first_gnt, we_busy, a0, a1, s0, s1, l1_data);
    chk_i("c5_no_done", n_done, 0);

    // 6: NUM_LAYERS=3, ACT_LAT=3
    begin
      int last_act, n_act, n_vb, gap_ok, d_at;
      last_act = -100; n_act = 0; n_vb = 0; gap_ok = 0; d_at = -1;
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (act_en_b) begin n_act++; last_act = i; end
        if (vec_we_b) begin
          n_vb++;
          if (i - last_act == 3) gap_ok++;
        end
        if (done_b && d_at < 0) d_at = i;
        tick();
      end
      chk_i("c6_act_cnt", n_act, 3);
      chk_i("c6_vec_cnt", n_vb, 3);
      chk_i("c6_gap", gap_ok, 3);
      chk_i("c6_done_at", d_at, 24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
